// File: rtl/motor_current_control_if.sv
// motor_current_control_if
//   Bundles the signals between the assistance algorithm / current sensing
//   side (master) and the motor current controller (slave).
//
//   Handshake: current_valid is a single-cycle strobe qualifying
//   current_sample. There is no ready signal because the controller can
//   accept a sample on every clock, so a sample is consumed in exactly the
//   cycle current_valid is high. AssistanceRequirement and brake are level
//   signals, sampled continuously.
//
//   Signals
//     AssistanceRequirement [12:0]  torque command, bit 12 = invalid/negative
//     brake                         brake lever, high kills drive
//     current_sample [11:0]         unsigned motor current ADC value
//     current_valid                 strobe qualifying current_sample
//     pwm_out                       gate-drive PWM
//     duty [9:0]                    duty currently applied, in counts
//     period_start                  one-cycle pulse while period counter is 0
//     fault                         high while in FAULT
//     fault_count [7:0]             saturating count of overcurrent trips
//     state_dbg [1:0]               controller FSM state, for observation
interface motor_current_control_if;
  logic [12:0] AssistanceRequirement;
  logic        brake;
  logic [11:0] current_sample;
  logic        current_valid;
  logic        pwm_out;
  logic [9:0]  duty;
  logic        period_start;
  logic        fault;
  logic [7:0]  fault_count;
  logic [1:0]  state_dbg;

  modport master (
    output AssistanceRequirement,
    output brake,
    output current_sample,
    output current_valid,
    input  pwm_out,
    input  duty,
    input  period_start,
    input  fault,
    input  fault_count,
    input  state_dbg
  );

  modport slave (
    input  AssistanceRequirement,
    input  brake,
    input  current_sample,
    input  current_valid,
    output pwm_out,
    output duty,
    output period_start,
    output fault,
    output fault_count,
    output state_dbg
  );
endinterface

// File: rtl/motor_current_control.sv
// motor_current_control
//   Turns the 13-bit assistance torque command into a slew-limited PWM duty
//   cycle, watches sampled motor current for overcurrent and enforces brake
//   and fault shutdown of the gate drive.
//
//   Parameters
//     PWM_PERIOD  PWM period in clk cycles (2..1023)
//     DUTY_STEP   maximum duty increase per PWM period
//     OC_LIMIT    overcurrent threshold (trip when sample is strictly greater)
//     FAULT_HOLD  PWM periods spent in FAULT before retrying
//
//   Ports
//     clk      system clock
//     reset_n  asynchronous active-low reset
//     mcc      motor_current_control_if.slave (command, brake, current
//              sample in; pwm_out, duty, period_start, fault, fault_count,
//              state_dbg out)
module motor_current_control #(
  parameter int          PWM_PERIOD = 1000,
  parameter int          DUTY_STEP  = 4,
  parameter logic [11:0] OC_LIMIT   = 12'd3500,
  parameter int          FAULT_HOLD = 500
) (
  input  logic                     clk,
  input  logic                     reset_n,
  motor_current_control_if.slave   mcc
);

  localparam int HOLD_W = (FAULT_HOLD < 2) ? 1 : $clog2(FAULT_HOLD + 1);

  localparam logic [9:0]  PERIOD_LEN  = 10'(PWM_PERIOD);
  localparam logic [9:0]  PERIOD_LAST = 10'(PWM_PERIOD - 1);
  localparam logic [10:0] STEP        = 11'(DUTY_STEP);
  localparam logic [HOLD_W-1:0] HOLD_LEN = HOLD_W'(FAULT_HOLD);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RAMP  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  // registered state
  logic [9:0]        cnt;
  logic [1:0]        state;
  logic [9:0]        duty_r;
  logic              pwm_r;
  logic              ps_r;
  logic [7:0]        fcnt;
  logic [HOLD_W-1:0] hold;

  // combinational helpers
  logic [11:0] cmd;
  logic [21:0] product;
  logic [9:0]  target;
  logic        boundary;
  logic        oc_trip;
  logic [10:0] stepped;
  logic [9:0]  ramp_duty;
  logic        hold_done;

  always_comb begin
    cmd      = mcc.AssistanceRequirement[12] ? 12'd0
                                             : mcc.AssistanceRequirement[11:0];
    // cmd is a fraction of full scale (4096); scaling by the period and
    // dropping 12 bits keeps the target strictly below PWM_PERIOD.
    product  = {10'd0, cmd} * {12'd0, PERIOD_LEN};
    target   = mcc.brake ? 10'd0 : 10'(product >> 12);
    boundary = (cnt == PERIOD_LAST);
    oc_trip  = mcc.current_valid && (mcc.current_sample > OC_LIMIT);
    stepped  = {1'b0, duty_r} + STEP;
    // Upward moves are slew limited; downward moves land on target at once.
    if (target > duty_r) begin
      ramp_duty = (stepped < {1'b0, target}) ? stepped[9:0] : target;
    end else begin
      ramp_duty = target;
    end
    hold_done = (hold >= HOLD_LEN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= 10'd0;
      state  <= ST_IDLE;
      duty_r <= 10'd0;
      pwm_r  <= 1'b0;
      ps_r   <= 1'b0;
      fcnt   <= 8'd0;
      hold   <= '0;
    end else begin
      cnt  <= boundary ? 10'd0 : cnt + 10'd1;
      // The counter wraps to 0 on this edge, so the pulse lines up with it.
      ps_r <= boundary;
      // oc_trip is included so the gate drive drops on the same edge the
      // FSM enters FAULT rather than one cycle later.
      pwm_r <= (cnt < duty_r) && (state != ST_FAULT) && !oc_trip && !mcc.brake;

      if (oc_trip) begin
        // Overcurrent overrides any boundary update in the same cycle.
        state  <= ST_FAULT;
        duty_r <= 10'd0;
        hold   <= '0;
        if ((state != ST_FAULT) && (fcnt != 8'hff)) begin
          fcnt <= fcnt + 8'd1;
        end
      end else begin
        case (state)
          ST_FAULT: begin
            if (ps_r && !hold_done) begin
              hold <= hold + HOLD_W'(1);
            end
            if (boundary && hold_done) begin
              state <= ST_IDLE;
            end
          end
          ST_IDLE: begin
            if (boundary && (target != 10'd0)) begin
              duty_r <= ramp_duty;
              state  <= ST_RAMP;
            end
          end
          default: begin
            // RAMP and RUN share the boundary update; the next state
            // follows from where the new duty sits relative to target.
            if (boundary) begin
              duty_r <= ramp_duty;
              if (target == 10'd0) begin
                state <= ST_IDLE;
              end else if (ramp_duty == target) begin
                state <= ST_RUN;
              end else begin
                state <= ST_RAMP;
              end
            end
          end
        endcase
      end
    end
  end

  assign mcc.pwm_out      = pwm_r;
  assign mcc.duty         = duty_r;
  assign mcc.period_start = ps_r;
  assign mcc.fault        = (state == ST_FAULT);
  assign mcc.fault_count  = fcnt;
  assign mcc.state_dbg    = state;

endmodule

// File: tb/tb_motor_current_control.sv
module tb_motor_current_control;
  localparam int P    = 100;
  localparam int STEP = 4;
  localparam int OC   = 3500;
  localparam int HOLD = 3;
  localparam int P2   = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  motor_current_control_if bus();
  motor_current_control_if bus2();

  motor_current_control #(
    .PWM_PERIOD(P), .DUTY_STEP(STEP), .OC_LIMIT(12'd3500), .FAULT_HOLD(HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mcc(bus)
  );

  // Short-period instance so saturating the trip counter stays cheap.
  motor_current_control #(
    .PWM_PERIOD(P2), .DUTY_STEP(STEP), .OC_LIMIT(12'd3500), .FAULT_HOLD(1)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .mcc(bus2)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];
  int md = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // reference model
  function automatic int model_target(input logic [12:0] c, input logic b);
    if (b || c[12]) return 0;
    return (int'(c[11:0]) * P) / 4096;
  endfunction

  function automatic int model_next(input int d, input int t);
    if (t > d) return (d + STEP < t) ? d + STEP : t;
    return t;
  endfunction

  // driver tasks
  task automatic wait_ps(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.period_start !== 1'b1 && n < 2 * P);
    if (bus.period_start !== 1'b1) check({tag, "_ps_timeout"}, 32'(bus.period_start), 1);
  endtask

  // One full period: check the duty applied this period, apply new inputs,
  // queue the duty expected at the next boundary, count PWM high cycles.
  task automatic do_period(input logic [12:0] c, input logic b, input string tag);
    int hi;
    logic [9:0] e;
    logic [11:0] s;
    wait_ps(tag);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'd0;
    check({tag, "_duty"}, 32'(bus.duty), 32'(e));
    bus.AssistanceRequirement = c;
    bus.brake = b;
    md = model_next(md, model_target(c, b));
    exp_q.push_back(10'(md));
    s = ($urandom_range(0, 1) == 1) ? 12'(OC) : 12'($urandom_range(0, OC));
    hi = 0;
    for (int i = 1; i < P; i++) begin
      @(negedge clk);
      if (bus.pwm_out === 1'b1) hi++;
      if (i == 50) begin
        bus.current_sample = s;
        bus.current_valid = 1'b1;
      end else begin
        bus.current_valid = 1'b0;
      end
    end
    check({tag, "_pwm_hi"}, 32'(hi), b ? 32'd0 : 32'(e));
    check({tag, "_no_trip"}, 32'(bus.fault), 0);
  endtask

  task automatic pulse_oc(input logic [11:0] s);
    bus.current_sample = s;
    bus.current_valid = 1'b1;
    @(negedge clk);
    bus.current_valid = 1'b0;
  endtask

  initial begin
    logic [9:0] e;
    int n;
    bus.AssistanceRequirement = 13'd0;
    bus.brake = 1'b0;
    bus.current_sample = 12'd0;
    bus.current_valid = 1'b0;
    bus2.AssistanceRequirement = 13'd0;
    bus2.brake = 1'b0;
    bus2.current_sample = 12'd0;
    bus2.current_valid = 1'b0;

    // reset state
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(bus.pwm_out), 0);
    check("rst_duty", 32'(bus.duty), 0);
    check("rst_ps", 32'(bus.period_start), 0);
    check("rst_fault", 32'(bus.fault), 0);
    check("rst_fcnt", 32'(bus.fault_count), 0);

    // ramp from 0 to target 50
    bus.AssistanceRequirement = 13'd2048;
    md = model_next(0, model_target(13'd2048, 1'b0));
    exp_q.push_back(10'(md));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (14) do_period(13'd2048, 1'b0, "ramp");

    // drop without slew, then invalid command
    do_period(13'd1024, 1'b0, "drop");
    do_period(13'h1800, 1'b0, "inv");
    repeat (13) do_period(13'd2048, 1'b0, "ramp2");

    // brake mid-period
    wait_ps("brk");
    e = exp_q.pop_front();
    check("brk_duty", 32'(bus.duty), 32'(e));
    md = model_next(md, model_target(bus.AssistanceRequirement, 1'b1));
    exp_q.push_back(10'(md));
    repeat (10) @(negedge clk);
    check("brk_pwm_before", 32'(bus.pwm_out), 1);
    bus.brake = 1'b1;
    @(negedge clk);
    check("brk_pwm_after", 32'(bus.pwm_out), 0);
    do_period(13'd2048, 1'b0, "brk_rel");
    repeat (2) do_period(13'd2048, 1'b0, "reramp");

    // randomized commands and brake
    for (int k = 0; k < 20; k++) begin
      logic [12:0] c;
      logic b;
      c = 13'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) == 0) c[12] = 1'b1;
      b = ($urandom_range(0, 3) == 0);
      do_period(c, b, "rand");
    end
    do_period(13'd2048, 1'b0, "pre_trip");

    // overcurrent threshold and trip
    wait_ps("trip");
    e = exp_q.pop_front();
    check("trip_pre_duty", 32'(bus.duty), 32'(e));
    repeat (20) @(negedge clk);
    pulse_oc(12'd3500);
    check("oc_eq_limit", 32'(bus.fault), 0);
    pulse_oc(12'd3501);
    check("trip_fault", 32'(bus.fault), 1);
    check("trip_pwm", 32'(bus.pwm_out), 0);
    check("trip_duty", 32'(bus.duty), 0);
    check("trip_fcnt", 32'(bus.fault_count), 1);

    // hold, retrip during hold restarts it
    for (int k = 0; k < 2; k++) begin
      wait_ps("hold_a");
      check("hold_a_fault", 32'(bus.fault), 1);
    end
    repeat (30) @(negedge clk);
    pulse_oc(12'd4000);
    check("retrip_fcnt", 32'(bus.fault_count), 1);
    for (int k = 0; k < HOLD; k++) begin
      wait_ps("hold_b");
      check("hold_b_fault", 32'(bus.fault), 1);
      check("hold_b_duty", 32'(bus.duty), 0);
    end
    wait_ps("recover");
    check("recover_fault", 32'(bus.fault), 0);
    check("recover_duty", 32'(bus.duty), 0);
    check("recover_fcnt", 32'(bus.fault_count), 1);
    md = model_next(0, model_target(bus.AssistanceRequirement, bus.brake));
    exp_q.push_back(10'(md));
    repeat (3) do_period(13'd2048, 1'b0, "post_fault");

    // saturate the trip counter (brake randomly asserted as well)
    for (int t = 1; t <= 258; t++) begin
      bus2.brake = 1'($urandom_range(0, 1));
      bus2.current_sample = 12'($urandom_range(OC + 1, 4095));
      bus2.current_valid = 1'b1;
      @(negedge clk);
      bus2.current_valid = 1'b0;
      check("sat_fault", 32'(bus2.fault), 1);
      check("sat_fcnt", 32'(bus2.fault_count), (t > 255) ? 32'd255 : 32'(t));
      n = 0;
      while (bus2.fault !== 1'b0 && n < 6 * P2) begin
        @(negedge clk);
        n++;
      end
      if (bus2.fault !== 1'b0) check("sat_recover_timeout", 32'(bus2.fault), 0);
    end

    // async reset while in FAULT
    bus.current_sample = 12'd4000;
    bus.current_valid = 1'b1;
    bus2.current_sample = 12'd4000;
    bus2.current_valid = 1'b1;
    @(negedge clk);
    bus.current_valid = 1'b0;
    bus2.current_valid = 1'b0;
    check("final_fault", 32'(bus.fault), 1);
    check("final_fcnt2", 32'(bus2.fault_count), 255);
    #2 reset_n = 1'b0;
    #1;
    check("arst_pwm", 32'(bus.pwm_out), 0);
    check("arst_duty", 32'(bus.duty), 0);
    check("arst_ps", 32'(bus.period_start), 0);
    check("arst_fault", 32'(bus.fault), 0);
    check("arst_fcnt", 32'(bus.fault_count), 0);
    check("arst_fault2", 32'(bus2.fault), 0);
    check("arst_fcnt2", 32'(bus2.fault_count), 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/motor_current_control.md
Name: motor_current_control

Overview:
- Consumer end of the AssistanceRequirement interface from the assistance algorithm.
- Converts the 13-bit assistance torque command into a slew-limited PWM duty cycle for the motor driver.
- Monitors sampled motor current for overcurrent and enforces brake and fault shutdown.
- Sits between the assistance algorithm and the motor gate-driver pin.

Parameters:
- PWM_PERIOD, 1000, PWM period in clk cycles (50 kHz at 50 MHz); legal range 2..1023.
- DUTY_STEP, 4, maximum duty increase per PWM period in counts.
- OC_LIMIT, 12'd3500, overcurrent threshold in raw ADC counts; trips when the sample is strictly greater.
- FAULT_HOLD, 500, minimum number of PWM periods spent in FAULT before retry.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- AssistanceRequirement  input  13  torque command; bit 12 set means invalid/negative and is treated as 0
- brake  input  1  brake lever; high kills drive
- current_sample  input  12  unsigned motor current ADC value
- current_valid  input  1  one-cycle strobe qualifying current_sample
- pwm_out  output  1  gate-drive PWM
- duty  output  10  duty currently applied, in counts
- period_start  output  1  one-cycle pulse while the period counter equals 0
- fault  output  1  high while in FAULT
- fault_count  output  8  saturating count of overcurrent trips

Behaviour:
- Reset is asynchronous on reset_n low. On reset:
  - pwm_out=0, duty=0, period_start=0, fault=0, fault_count=0.
  - Period counter=0, state=IDLE, hold counter=0.
- Period counter:
  - Counts 0..PWM_PERIOD-1 and wraps to 0.
  - Free-runs in every state.
- period_start is registered and is high in the cycle the counter equals 0.
- pwm_out is registered: pwm_out = (counter < duty) and state is not FAULT and brake is low.
  - It therefore drops at most 1 cycle after brake or a fault trip.
- Target duty is combinational:
  - cmd = AssistanceRequirement[12] ? 0 : AssistanceRequirement[11:0].
  - target = (cmd * PWM_PERIOD) >> 12, using a 22-bit product, truncated toward zero, always < PWM_PERIOD.
  - brake high forces target = 0.
- Duty updates only when counter = PWM_PERIOD-1, so the new duty takes effect from the next counter = 0.
  - target > duty: duty <= min(duty + DUTY_STEP, target).
  - target <= duty: duty <= target immediately (no down-slew limit).
- State machine:
  - IDLE: duty = 0. Go to RAMP when target > 0 at a period boundary.
  - RAMP: duty < target. Go to RUN when duty reaches target. Go to IDLE when target = 0.
  - RUN: duty = target. Re-enter RAMP if target rises above duty. Go to IDLE if target = 0.
  - FAULT:
    - Entered from any non-FAULT state in the cycle after current_valid=1 with current_sample > OC_LIMIT.
    - On entry: duty <= 0 immediately (not waiting for a boundary), fault=1, fault_count increments (saturates at 255), hold counter cleared.
    - Hold counter increments on each period_start.
    - After FAULT_HOLD periods, return to IDLE at the next period boundary; duty then re-ramps from 0.
    - Further overcurrent samples while in FAULT restart the hold counter and do not increment fault_count.
- Simultaneous events:
  - Overcurrent on the same cycle as a period boundary: FAULT wins and duty = 0.
  - Brake plus overcurrent: FAULT is entered; brake alone never sets fault.
- current_valid with sample = OC_LIMIT exactly does not trip.
- Reset asserted mid-period or in FAULT: returns immediately to the reset values; the fault history is lost.

Test Plan:
- PWM_PERIOD=100, DUTY_STEP=4, cmd=2048, brake=0 -> target 50; duty steps 4, 8, … 48, 50 at successive period boundaries; RUN after 13 periods; pwm_out high 50 of 100 cycles.
- In RUN at duty=50, cmd drops to 1024 -> duty=25 at the next boundary with no slew; cmd=13'h1800 (bit 12 set) -> duty=0 and state=IDLE.
- Duty 50, brake asserted mid-period -> pwm_out low on the next cycle, duty=0 at the boundary; brake released -> re-ramp from 0 by 4 per period.
- current_sample=3500 with valid -> no trip; 3501 with valid -> fault=1 and pwm_out=0 next cycle, duty=0, fault_count=1.
- FAULT_HOLD=3 -> fault stays high for 3 periods, then IDLE and re-ramp. A second trip during the hold resets the hold counter and leaves fault_count=1.
- Force 256 trips -> fault_count holds 255. Assert reset_n low during FAULT -> all outputs are 0 asynchronously.
